// File: rtl/seg7_scan_ctrl.sv
// Digit-scan timing for a 4-digit multiplexed 7-segment display: one-hot
// anode select with a dead-time blank window and a brightness on-window per slot.
module seg7_scan_ctrl #(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [2:0] bright,
    input  logic [3:0] digit_en,
    output logic [3:0] an,
    output logic [3:0] an_n,
    output logic [1:0] digit_idx,
    output logic       frame_tick
);

    localparam int              CW      = $clog2(CLK_DIV);
    localparam logic [CW-1:0]   CNT_MAX = CW'(CLK_DIV - 1);
    localparam logic [31:0]     BLANK_U = 32'(BLANK_CYCLES);
    localparam logic [31:0]     SPAN_U  = 32'((CLK_DIV - BLANK_CYCLES) / 8);

    logic [CW-1:0] cnt, cnt_nx;
    logic [1:0]    idx, idx_nx;
    logic [2:0]    bright_q, bright_nx;
    logic [3:0]    mask_q, mask_nx;
    logic          restart_q, restart_nx;
    logic [3:0]    an_nx;
    logic          tick_nx;
    logic          wrap;
    logic          lit;
    logic [31:0]   cnt_ext;
    logic [31:0]   win_end;

    assign digit_idx = idx;

    always_comb begin
        cnt_nx     = cnt;
        idx_nx     = idx;
        bright_nx  = bright_q;
        mask_nx    = mask_q;
        restart_nx = restart_q;
        wrap       = (cnt == CNT_MAX);
        if (!enable) begin
            cnt_nx     = '0;
            idx_nx     = 2'd0;
            restart_nx = 1'b1;
            bright_nx  = bright;
            mask_nx    = digit_en;
        end else begin
            cnt_nx     = wrap ? '0 : cnt + CW'(1);
            idx_nx     = wrap ? idx + 2'd1 : idx;
            restart_nx = 1'b0;
            // The first enabled edge after reset/disable also latches, so slot 0 sees live settings.
            if (wrap || restart_q) begin
                bright_nx = bright;
                mask_nx   = digit_en;
            end
        end
    end

    // Outputs are computed from the next-state values so the flops line up with cnt/idx.
    always_comb begin
        cnt_ext = 32'(cnt_nx);
        win_end = BLANK_U + SPAN_U * (32'(bright_nx) + 32'd1);
        lit     = enable && mask_nx[2'd3 - idx_nx] &&
                  (cnt_ext >= BLANK_U) && (cnt_ext < win_end);
        an_nx   = lit ? (4'b1000 >> idx_nx) : 4'b0000;
        tick_nx = enable && (cnt_nx == CNT_MAX) && (idx_nx == 2'd3);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            idx        <= 2'd0;
            bright_q   <= 3'd0;
            mask_q     <= 4'b0000;
            restart_q  <= 1'b1;
            an         <= 4'b0000;
            an_n       <= 4'b1111;
            frame_tick <= 1'b0;
        end else begin
            cnt        <= cnt_nx;
            idx        <= idx_nx;
            bright_q   <= bright_nx;
            mask_q     <= mask_nx;
            restart_q  <= restart_nx;
            an         <= an_nx;
            an_n       <= ~an_nx;
            frame_tick <= tick_nx;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: directed scenarios plus randomized inputs checked
// against an elapsed-time model of the scan schedule.
module tb_seg7_scan_ctrl;

    localparam int CD = 16;
    localparam int BL = 8;
    localparam int SP = (CD - BL) / 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [2:0] bright = 3'd7;
    logic [3:0] digit_en = 4'hF;
    logic [3:0] an, an_n;
    logic [1:0] digit_idx;
    logic       frame_tick;

    int vectors = 0;
    int miscompares = 0;

    seg7_scan_ctrl #(.CLK_DIV(CD), .BLANK_CYCLES(BL)) dut (
        .clk(clk), .reset(reset), .enable(enable), .bright(bright),
        .digit_en(digit_en), .an(an), .an_n(an_n), .digit_idx(digit_idx),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // Model: e = enabled clock edges since the last restart; slot settings are
    // captured on the edge that opens each slot.
    int         e = 0;
    logic       fresh = 1'b1;
    logic [2:0] cur_b = 3'd0;
    logic [3:0] cur_m = 4'd0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            e = 0; fresh = 1'b1; cur_b = 3'd0; cur_m = 4'd0;
        end else if (!enable) begin
            e = 0; fresh = 1'b1;
        end else begin
            if (fresh || ((e + 1) % CD == 0)) begin
                cur_b = bright; cur_m = digit_en;
            end
            fresh = 1'b0;
            e = e + 1;
        end
    end

    function automatic int m_pos(); return e % CD; endfunction
    function automatic int m_slot(); return (e / CD) % 4; endfunction
    function automatic logic [3:0] m_an();
        logic [3:0] code;
        code = 4'b1000 >> m_slot();
        if (cur_m[3 - m_slot()] && m_pos() >= BL && m_pos() < BL + SP * (int'(cur_b) + 1))
            return code;
        return 4'b0000;
    endfunction
    function automatic logic m_ft(); return (m_pos() == CD - 1) && (m_slot() == 3); endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        enable = 1'b1; bright = 3'd7; digit_en = 4'hF;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if ({an, an_n, digit_idx, frame_tick} !== {4'h0, 4'hF, 2'd0, 1'b0}) begin
                miscompares++;
                $display("FAIL reset_state: an=%b an_n=%b idx=%0d ft=%b, required 0000 1111 0 0",
                         an, an_n, digit_idx, frame_tick);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_full_bright();
        int pulses;
        logic [3:0] exp;
        pulses = 0;
        enable = 1'b1; bright = 3'd7; digit_en = 4'hF;
        do_reset();
        for (int n = 1; n <= 128; n++) begin
            tick();
            exp = ((n % 16) >= 8) ? (4'b1000 >> ((n / 16) % 4)) : 4'b0000;
            vectors++;
            if (an !== exp || an_n !== ~exp || digit_idx !== 2'((n / 16) % 4)) begin
                miscompares++;
                $display("FAIL full_bright n=%0d: an=%b an_n=%b idx=%0d, required an=%b idx=%0d",
                         n, an, an_n, digit_idx, exp, (n / 16) % 4);
            end
            if (frame_tick) begin
                pulses++;
                vectors++;
                if (n % 64 != 63) begin
                    miscompares++;
                    $display("FAIL frame_tick_pos: pulse at n=%0d, required n%%64=63", n);
                end
            end
        end
        vectors++;
        if (pulses != 2) begin
            miscompares++;
            $display("FAIL frame_tick_count: %0d pulses in 128 cycles, required 2", pulses);
        end
    endtask

    task automatic test_bright_levels();
        int lit;
        int levels[2] = '{0, 3};
        digit_en = 4'hF; enable = 1'b1;
        foreach (levels[i]) begin
            bright = 3'(levels[i]);
            do tick(); while (m_pos() != CD - 1);
            lit = 0;
            for (int k = 0; k < CD; k++) begin
                tick();
                if (an != 4'b0000) lit++;
                vectors++;
                if (an !== m_an()) begin
                    miscompares++;
                    $display("FAIL bright_%0d pos=%0d: an=%b, required %b", levels[i], m_pos(), an, m_an());
                end
            end
            vectors++;
            if (lit != levels[i] + 1) begin
                miscompares++;
                $display("FAIL bright_%0d_width: lit %0d cycles, required %0d", levels[i], lit, levels[i] + 1);
            end
        end
        // Raise brightness mid-slot: current slot keeps 1 lit cycle, next gets 8.
        bright = 3'd0;
        do tick(); while (m_pos() != CD - 1);
        lit = 0;
        for (int k = 0; k < 2 * CD; k++) begin
            tick();
            if (m_pos() == 10 && k < CD) bright = 3'd7;
            if (an != 4'b0000) lit++;
            if (k == CD - 1) begin
                vectors++;
                if (lit != 1) begin
                    miscompares++;
                    $display("FAIL bright_midslot_cur: lit %0d cycles, required 1", lit);
                end
                lit = 0;
            end
        end
        vectors++;
        if (lit != 8) begin
            miscompares++;
            $display("FAIL bright_midslot_next: lit %0d cycles, required 8", lit);
        end
    endtask

    task automatic test_mask();
        int pulses;
        pulses = 0;
        enable = 1'b1; bright = 3'd7; digit_en = 4'b1010;
        do_reset();
        for (int n = 1; n <= 128; n++) begin
            tick();
            vectors++;
            if (an !== m_an() || !(an inside {4'b0000, 4'b1000, 4'b0010})) begin
                miscompares++;
                $display("FAIL mask n=%0d: an=%b, required %b", n, an, m_an());
            end
            if (frame_tick) begin
                pulses++;
                vectors++;
                if (n % 64 != 63) begin
                    miscompares++;
                    $display("FAIL mask_tick_pos: pulse at n=%0d, required n%%64=63", n);
                end
            end
        end
        vectors++;
        if (pulses != 2) begin
            miscompares++;
            $display("FAIL mask_tick_count: %0d pulses, required 2", pulses);
        end
    endtask

    task automatic test_enable_drop();
        logic [3:0] exp;
        enable = 1'b1; bright = 3'd7; digit_en = 4'hF;
        do_reset();
        for (int n = 0; n < 44; n++) tick();
        enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            vectors++;
            if ({an, an_n, digit_idx, frame_tick} !== {4'h0, 4'hF, 2'd0, 1'b0}) begin
                miscompares++;
                $display("FAIL disabled k=%0d: an=%b an_n=%b idx=%0d ft=%b, required 0000 1111 0 0",
                         k, an, an_n, digit_idx, frame_tick);
            end
        end
        enable = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp = (k == 8) ? 4'b1000 : 4'b0000;
            vectors++;
            if (an !== exp || digit_idx !== 2'd0) begin
                miscompares++;
                $display("FAIL reenable k=%0d: an=%b idx=%0d, required an=%b idx=0", k, an, digit_idx, exp);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] exp;
        enable = 1'b1; bright = 3'd7; digit_en = 4'hF;
        do_reset();
        for (int n = 0; n < 10; n++) tick();
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({an, an_n, digit_idx, frame_tick} !== {4'h0, 4'hF, 2'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL async_reset: an=%b an_n=%b idx=%0d ft=%b, required 0000 1111 0 0",
                     an, an_n, digit_idx, frame_tick);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp = (k == 8) ? 4'b1000 : 4'b0000;
            vectors++;
            if (an !== exp || digit_idx !== 2'd0) begin
                miscompares++;
                $display("FAIL after_reset k=%0d: an=%b idx=%0d, required an=%b idx=0", k, an, digit_idx, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] last_code;
        int zero_run;
        last_code = 4'b0000;
        zero_run = 0;
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(0, 63) == 0) enable = ~enable;
            if (!enable && $urandom_range(0, 7) == 0) enable = 1'b1;
            if ($urandom_range(0, 7) == 0) bright = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) digit_en = 4'($urandom_range(0, 15));
            tick();
            vectors++;
            if (an !== m_an() || an_n !== ~m_an() || digit_idx !== 2'(m_slot()) || frame_tick !== m_ft()) begin
                miscompares++;
                $display("FAIL random n=%0d: an=%b an_n=%b idx=%0d ft=%b, required an=%b idx=%0d ft=%b",
                         n, an, an_n, digit_idx, frame_tick, m_an(), m_slot(), m_ft());
            end
            vectors++;
            if ($countones(an) > 1) begin
                miscompares++;
                $display("FAIL onehot n=%0d: an=%b, required one-hot or zero", n, an);
            end
            if (an == 4'b0000) begin
                zero_run++;
            end else begin
                if (last_code != 4'b0000 && an != last_code) begin
                    vectors++;
                    if (zero_run < BL) begin
                        miscompares++;
                        $display("FAIL dead_time n=%0d: %0d blank cycles between %b and %b, required >= %0d",
                                 n, zero_run, last_code, an, BL);
                    end
                end
                last_code = an;
                zero_run = 0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_bright();
        test_bright_levels();
        test_mask();
        test_enable_drop();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
